// File: rtl/mux_rr_arbiter_if.sv
// Requester/consumer bundle around the round-robin mux arbiter.
// slave = arbiter side, master = requester/consumer side.
interface mux_rr_arbiter_if #(
  parameter int NB_input = 3
);
  logic [2:0]        e_req;
  logic [2:0]        e_last;
  logic [NB_input:0] e_mux1;
  logic [NB_input:0] e_mux2;
  logic [NB_input:0] e_mux3;
  logic              e_ready;
  logic [2:0]        s_ack;
  logic [1:0]        s_muxsel;
  logic              s_valid;
  logic [NB_input:0] s_data;
  logic [1:0]        s_src;
  logic              s_lastout;

  modport slave (
    input  e_req, e_last, e_mux1, e_mux2, e_mux3, e_ready,
    output s_ack, s_muxsel, s_valid, s_data, s_src, s_lastout
  );

  modport master (
    output e_req, e_last, e_mux1, e_mux2, e_mux3, e_ready,
    input  s_ack, s_muxsel, s_valid, s_data, s_src, s_lastout
  );
endinterface

// File: rtl/mux_rr_arbiter.sv
// Round-robin burst arbiter owning the 3:1 mux select, with one registered output stage.
// Define MUXARB_FIXED_PRIO_EN to replace round robin with fixed priority 0>1>2.
module mux_rr_arbiter #(
  parameter int NB_input  = 3,
  parameter int MAX_BURST = 8
) (
  input  logic               clk,
  input  logic               rst,
  mux_rr_arbiter_if.slave    bus
);
  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [7:0] L_MAX = 8'(MAX_BURST);

  state_t            r_state, w_state_next;
  logic [1:0]        r_muxsel, w_muxsel_next;
  logic [7:0]        r_cnt, w_cnt_next;
  logic              r_valid, w_valid_next;
  logic [NB_input:0] r_data, w_data_next;
  logic [1:0]        r_src, w_src_next;
  logic              r_last, w_last_next;

  logic [2:0]        w_gmask;
  logic [2:0]        w_ack;
  logic              w_req_g, w_last_g, w_accept, w_release;
  logic [1:0]        w_winner;
  logic [NB_input:0] w_sel_data;

  // One-hot view of the current grant; all zeros when select is 11.
  for (genvar gi = 0; gi < 3; gi++) begin : g_grant
    assign w_gmask[gi] = (r_muxsel == 2'(gi));
    assign w_ack[gi]   = w_accept && w_gmask[gi];
  end

  assign w_req_g   = |(bus.e_req & w_gmask);
  assign w_last_g  = |(bus.e_last & w_gmask);
  assign w_accept  = (r_state == BUSY) && w_req_g && (!r_valid || bus.e_ready);
  assign w_release = w_accept && (w_last_g || ((r_cnt + 8'd1) == L_MAX));

  always_comb begin
    case (r_muxsel)
      2'd0:    w_sel_data = bus.e_mux1;
      2'd1:    w_sel_data = bus.e_mux2;
      2'd2:    w_sel_data = bus.e_mux3;
      default: w_sel_data = '0;
    endcase
  end

`ifdef MUXARB_FIXED_PRIO_EN
  always_comb begin
    w_winner = 2'd3;
    if (bus.e_req[0])      w_winner = 2'd0;
    else if (bus.e_req[1]) w_winner = 2'd1;
    else if (bus.e_req[2]) w_winner = 2'd2;
  end
`else
  logic [1:0] r_ptr, w_ptr_next;

  // Search starts just after the last requester served.
  always_comb begin
    w_winner = 2'd3;
    case (r_ptr)
      2'd0: begin
        if (bus.e_req[1])      w_winner = 2'd1;
        else if (bus.e_req[2]) w_winner = 2'd2;
        else if (bus.e_req[0]) w_winner = 2'd0;
      end
      2'd1: begin
        if (bus.e_req[2])      w_winner = 2'd2;
        else if (bus.e_req[0]) w_winner = 2'd0;
        else if (bus.e_req[1]) w_winner = 2'd1;
      end
      default: begin
        if (bus.e_req[0])      w_winner = 2'd0;
        else if (bus.e_req[1]) w_winner = 2'd1;
        else if (bus.e_req[2]) w_winner = 2'd2;
      end
    endcase
  end
`endif

  always_comb begin
    w_state_next  = r_state;
    w_muxsel_next = r_muxsel;
    w_cnt_next    = r_cnt;
`ifndef MUXARB_FIXED_PRIO_EN
    w_ptr_next    = r_ptr;
`endif
    w_valid_next  = r_valid;
    w_data_next   = r_data;
    w_src_next    = r_src;
    w_last_next   = r_last;
    case (r_state)
      IDLE: begin
        if (|bus.e_req) begin
          w_muxsel_next = w_winner;
          w_cnt_next    = 8'd0;
          w_state_next  = BUSY;
        end else begin
          w_muxsel_next = 2'b11;
        end
      end
      default: begin
        if (w_accept) w_cnt_next = r_cnt + 8'd1;
        if (w_release) begin
          w_state_next  = IDLE;
          w_muxsel_next = 2'b11;
          w_cnt_next    = 8'd0;
`ifndef MUXARB_FIXED_PRIO_EN
          w_ptr_next    = r_muxsel;
`endif
        end
      end
    endcase
    if (w_accept) begin
      w_valid_next = 1'b1;
      w_data_next  = w_sel_data;
      w_src_next   = r_muxsel;
      w_last_next  = w_last_g;
    end else if (r_valid && bus.e_ready) begin
      w_valid_next = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_muxsel <= 2'b11;
      r_cnt    <= 8'd0;
      r_valid  <= 1'b0;
      r_data   <= '0;
      r_src    <= 2'b11;
      r_last   <= 1'b0;
`ifndef MUXARB_FIXED_PRIO_EN
      r_ptr    <= 2'd2;
`endif
    end else begin
      r_state  <= w_state_next;
      r_muxsel <= w_muxsel_next;
      r_cnt    <= w_cnt_next;
      r_valid  <= w_valid_next;
      r_data   <= w_data_next;
      r_src    <= w_src_next;
      r_last   <= w_last_next;
`ifndef MUXARB_FIXED_PRIO_EN
      r_ptr    <= w_ptr_next;
`endif
    end
  end

  assign bus.s_ack     = w_ack;
  assign bus.s_muxsel  = r_muxsel;
  assign bus.s_valid   = r_valid;
  assign bus.s_data    = r_data;
  assign bus.s_src     = r_src;
  assign bus.s_lastout = r_last;
endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench for mux_rr_arbiter: reset, single beat, rotation, burst cap,
// downstream stall, reset mid-burst and requester drop-out.
module tb_mux_rr_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;

  mux_rr_arbiter_if #(.NB_input(3)) bus ();

  mux_rr_arbiter #(.NB_input(3), .MAX_BURST(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [2:0] ack_s;
  logic       xfer_s;
  logic [3:0] data_s;
  logic [1:0] src_s;
  logic [1:0] muxsel_s;

  // Sample pre-edge view (combinational ack, handshake), then advance one cycle.
  task automatic tick();
    #1;
    ack_s    = bus.s_ack;
    xfer_s   = bus.s_valid && bus.e_ready;
    data_s   = bus.s_data;
    src_s    = bus.s_src;
    muxsel_s = bus.s_muxsel;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.e_req = 3'b000; bus.e_last = 3'b000; bus.e_ready = 1'b1;
    bus.e_mux1 = 4'h0; bus.e_mux2 = 4'h0; bus.e_mux3 = 4'h0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.e_req = 3'b111; bus.e_last = 3'b000; bus.e_ready = 1'b1;
    bus.e_mux1 = 4'h5; bus.e_mux2 = 4'h6; bus.e_mux3 = 4'h7;
    tick(); tick();
    n_checks++; if (bus.s_muxsel !== 2'b11) begin n_fail++; $display("FAIL reset_muxsel got=%b exp=11", bus.s_muxsel); end
    n_checks++; if (bus.s_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", bus.s_valid); end
    n_checks++; if (bus.s_data !== 4'h0) begin n_fail++; $display("FAIL reset_data got=%h exp=0", bus.s_data); end
    n_checks++; if (bus.s_src !== 2'b11) begin n_fail++; $display("FAIL reset_src got=%b exp=11", bus.s_src); end
    n_checks++; if (bus.s_lastout !== 1'b0) begin n_fail++; $display("FAIL reset_lastout got=%b exp=0", bus.s_lastout); end
    n_checks++; if (bus.s_ack !== 3'b000) begin n_fail++; $display("FAIL reset_ack got=%b exp=000", bus.s_ack); end
    $display("reset: muxsel=%b valid=%b src=%b", bus.s_muxsel, bus.s_valid, bus.s_src);
  endtask

  task automatic test_single();
    do_reset();
    bus.e_req = 3'b001; bus.e_mux1 = 4'hA; bus.e_last = 3'b001;
    tick();
    n_checks++; if (bus.s_muxsel !== 2'b00) begin n_fail++; $display("FAIL single_grant got=%b exp=00", bus.s_muxsel); end
    n_checks++; if (bus.s_ack !== 3'b001) begin n_fail++; $display("FAIL single_ack got=%b exp=001", bus.s_ack); end
    tick();
    bus.e_req = 3'b000;
    n_checks++; if (bus.s_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid got=%b exp=1", bus.s_valid); end
    n_checks++; if (bus.s_data !== 4'hA) begin n_fail++; $display("FAIL single_data got=%h exp=a", bus.s_data); end
    n_checks++; if (bus.s_src !== 2'b00) begin n_fail++; $display("FAIL single_src got=%b exp=00", bus.s_src); end
    n_checks++; if (bus.s_lastout !== 1'b1) begin n_fail++; $display("FAIL single_lastout got=%b exp=1", bus.s_lastout); end
    n_checks++; if (bus.s_muxsel !== 2'b11) begin n_fail++; $display("FAIL single_release got=%b exp=11", bus.s_muxsel); end
    tick();
    n_checks++; if (bus.s_valid !== 1'b0) begin n_fail++; $display("FAIL single_drain got=%b exp=0", bus.s_valid); end
    $display("single: beat A from requester 0 delivered");
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_src [6];
    int n = 0;
    int prev_c = 0;
`ifdef MUXARB_FIXED_PRIO_EN
    exp_src = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
`else
    exp_src = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2};
`endif
    do_reset();
    bus.e_req = 3'b111; bus.e_last = 3'b111;
    bus.e_mux1 = 4'h1; bus.e_mux2 = 4'h2; bus.e_mux3 = 4'h3;
    for (int c = 0; c < 40 && n < 6; c++) begin
      tick();
      if (xfer_s) begin
        n_checks++; if (src_s !== exp_src[n]) begin n_fail++; $display("FAIL rr_src[%0d] got=%0d exp=%0d", n, src_s, exp_src[n]); end
        n_checks++; if (data_s !== 4'({2'b00, exp_src[n]} + 4'd1)) begin n_fail++; $display("FAIL rr_data[%0d] got=%h exp=%h", n, data_s, {2'b00, exp_src[n]} + 4'd1); end
        n_checks++; if (muxsel_s !== 2'b11) begin n_fail++; $display("FAIL rr_idle[%0d] muxsel got=%b exp=11", n, muxsel_s); end
        if (n > 0) begin
          n_checks++; if (c - prev_c != 2) begin n_fail++; $display("FAIL rr_gap[%0d] got=%0d exp=2", n, c - prev_c); end
        end
        $display("rr: beat %0d src=%0d data=%h", n, src_s, data_s);
        prev_c = c;
        n++;
      end
    end
    n_checks++; if (n != 6) begin n_fail++; $display("FAIL rr_timeout got=%0d beats exp=6", n); end
    bus.e_req = 3'b000;
  endtask

  task automatic test_burst_cap();
    int beat = 0;
    int nx = 0;
    int idle_cnt = 0;
    int idle_beat = -1;
    logic granted = 1'b0;
    do_reset();
    bus.e_req = 3'b010; bus.e_last = 3'b000; bus.e_mux2 = 4'h0;
    for (int c = 0; c < 60 && nx < 12; c++) begin
      tick();
      if (muxsel_s == 2'b01) granted = 1'b1;
      if (granted && muxsel_s == 2'b11) begin idle_cnt++; idle_beat = beat; end
      if (ack_s[1]) begin
        beat++;
        bus.e_mux2 = 4'(beat);
        if (beat == 12) bus.e_req = 3'b000;
      end
      if (xfer_s) begin
        n_checks++; if (data_s !== 4'(nx)) begin n_fail++; $display("FAIL cap_data[%0d] got=%h exp=%h", nx, data_s, 4'(nx)); end
        nx++;
      end
    end
    n_checks++; if (nx != 12) begin n_fail++; $display("FAIL cap_timeout got=%0d beats exp=12", nx); end
    n_checks++; if (idle_cnt != 1) begin n_fail++; $display("FAIL cap_idle_count got=%0d exp=1", idle_cnt); end
    n_checks++; if (idle_beat != 8) begin n_fail++; $display("FAIL cap_release_beat got=%0d exp=8", idle_beat); end
    $display("cap: %0d beats, release after beat %0d", nx, idle_beat);
  endtask

  task automatic test_stall();
    int beat = 0;
    int nx = 0;
    int stall_left = 3;
    do_reset();
    bus.e_req = 3'b010; bus.e_last = 3'b000; bus.e_mux2 = 4'h0;
    for (int c = 0; c < 60 && nx < 6; c++) begin
      bus.e_last = (beat == 5) ? 3'b010 : 3'b000;
      if (beat >= 2 && stall_left > 0) begin
        bus.e_ready = 1'b0;
        stall_left--;
      end else begin
        bus.e_ready = 1'b1;
      end
      tick();
      if (!bus.e_ready) begin
        n_checks++; if (ack_s !== 3'b000) begin n_fail++; $display("FAIL stall_ack got=%b exp=000", ack_s); end
        n_checks++; if (data_s !== 4'h1) begin n_fail++; $display("FAIL stall_data got=%h exp=1", data_s); end
      end
      if (ack_s[1]) begin
        beat++;
        bus.e_mux2 = 4'(beat);
        if (beat == 6) bus.e_req = 3'b000;
      end
      if (xfer_s) begin
        n_checks++; if (data_s !== 4'(nx)) begin n_fail++; $display("FAIL stall_seq[%0d] got=%h exp=%h", nx, data_s, 4'(nx)); end
        nx++;
      end
    end
    bus.e_ready = 1'b1;
    n_checks++; if (nx != 6) begin n_fail++; $display("FAIL stall_timeout got=%0d beats exp=6", nx); end
    $display("stall: %0d beats delivered across 3-cycle stall", nx);
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    bus.e_req = 3'b010; bus.e_last = 3'b010; bus.e_mux2 = 4'h5;
    tick(); tick();
    bus.e_req = 3'b000; bus.e_last = 3'b000;
    tick();
    bus.e_req = 3'b001; bus.e_mux1 = 4'h7;
    tick(); tick(); tick();
    n_checks++; if (bus.s_ack !== 3'b001) begin n_fail++; $display("FAIL mid_beat3_ack got=%b exp=001", bus.s_ack); end
    rst = 1'b1;
    tick();
    n_checks++; if (bus.s_valid !== 1'b0) begin n_fail++; $display("FAIL mid_valid got=%b exp=0", bus.s_valid); end
    n_checks++; if (bus.s_muxsel !== 2'b11) begin n_fail++; $display("FAIL mid_muxsel got=%b exp=11", bus.s_muxsel); end
    n_checks++; if (bus.s_src !== 2'b11) begin n_fail++; $display("FAIL mid_src got=%b exp=11", bus.s_src); end
    rst = 1'b0;
    bus.e_req = 3'b110;
    tick();
    n_checks++; if (bus.s_muxsel !== 2'b01) begin n_fail++; $display("FAIL mid_regrant got=%b exp=01", bus.s_muxsel); end
    $display("reset mid-burst: regrant muxsel=%b", bus.s_muxsel);
    bus.e_req = 3'b000;
  endtask

  task automatic test_drop();
    int beat = 0;
    int nx = 0;
    int drop_left = 2;
    logic dropped;
    do_reset();
    bus.e_req = 3'b001; bus.e_last = 3'b000; bus.e_mux1 = 4'h0;
    for (int c = 0; c < 40 && nx < 4; c++) begin
      dropped = 1'b0;
      if (beat == 2 && drop_left > 0) begin
        bus.e_req = 3'b000; drop_left--; dropped = 1'b1;
      end else if (beat < 4) begin
        bus.e_req = 3'b001;
      end else begin
        bus.e_req = 3'b000;
      end
      bus.e_last = (beat == 3) ? 3'b001 : 3'b000;
      tick();
      if (dropped) begin
        n_checks++; if (muxsel_s !== 2'b00) begin n_fail++; $display("FAIL drop_hold got=%b exp=00", muxsel_s); end
        n_checks++; if (ack_s !== 3'b000) begin n_fail++; $display("FAIL drop_ack got=%b exp=000", ack_s); end
      end
      if (ack_s[0]) begin
        beat++;
        bus.e_mux1 = 4'(beat);
        if (beat == 4) begin
          n_checks++; if (bus.s_muxsel !== 2'b11) begin n_fail++; $display("FAIL drop_release got=%b exp=11", bus.s_muxsel); end
        end
      end
      if (xfer_s) begin
        n_checks++; if (data_s !== 4'(nx)) begin n_fail++; $display("FAIL drop_seq[%0d] got=%h exp=%h", nx, data_s, 4'(nx)); end
        nx++;
      end
    end
    bus.e_req = 3'b000;
    n_checks++; if (nx != 4) begin n_fail++; $display("FAIL drop_timeout got=%0d beats exp=4", nx); end
    $display("drop: %0d beats delivered around 2-cycle request gap", nx);
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_burst_cap();
    test_stall();
    test_reset_mid_burst();
    test_drop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mux_rr_arbiter.md
Name: mux_rr_arbiter

Overview:
Round-robin arbiter that shares the 3-input datapath mux between three burst requesters. It generates the 2-bit select and drives per-requester accept strobes. The selected word is registered into a single output stage with a valid/ready handshake toward the downstream consumer. It sits in front of the mux and owns its select line; the mux itself stays combinational.

Parameters:
NB_input, 3, MSB index of data words (word width = NB_input+1, default 4 bits)
MAX_BURST, 8, maximum beats per grant before forced release (1..255)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
e_req  input  3  request/valid per requester; bit0 = e_mux1 source, bit1 = e_mux2, bit2 = e_mux3
e_last  input  3  per-requester end-of-burst flag, sampled with the beat
e_mux1  input  NB_input+1  requester 0 data
e_mux2  input  NB_input+1  requester 1 data
e_mux3  input  NB_input+1  requester 2 data
e_ready  input  1  downstream ready
s_ack  output  3  one-hot beat accept to requester (combinational)
s_muxsel  output  2  current grant/select: 00, 01, 10; 11 = no grant
s_valid  output  1  output word valid
s_data  output  NB_input+1  registered mux output
s_src  output  2  source index of s_data
s_lastout  output  1  registered e_last of the accepted beat

Behaviour:
- Reset (rst=1 at posedge): state IDLE; s_muxsel=2'b11; s_valid=0; s_data=0; s_src=2'b11; s_lastout=0; beat counter=0; RR pointer=2 (requester 0 has highest priority first). s_ack=0 while in IDLE.
- Reset mid-burst: immediate abort at that edge; no partial state kept; the in-flight s_valid word is dropped.
- FSM states: IDLE, BUSY.
- IDLE: if e_req!=0, select winner by priority order ptr+1, ptr+2, ptr+3 (mod 3); register s_muxsel=winner, counter=0, go to BUSY. If e_req==0, stay in IDLE with s_muxsel=11.
- BUSY: accept = e_req[g] && (!s_valid || e_ready), where g=s_muxsel. s_ack[g]=accept; other s_ack bits are 0.
- On accept: s_data<=selected word, s_src<=g, s_lastout<=e_last[g], s_valid<=1, counter<=counter+1.
- Release: on accept with e_last[g]=1, or when counter+1==MAX_BURST. State goes to IDLE, ptr<=g, s_muxsel<=11. A new arbitration happens on the following cycle; there is 1 idle cycle between grants.
- Requester drops e_req while granted: grant holds; no accept occurs; no release until last or the cap.
- Output stage: if s_valid && e_ready && !accept, then s_valid<=0. s_data holds while s_valid && !e_ready.
- Latency: request seen in IDLE at cycle n; grant at n+1; first accept at n+1; s_valid at n+2. Throughput is 1 beat/cycle while e_ready=1.
- Select 11 never reaches s_data. The mux default (zero) is never sampled.
- Counter width: 8 bits; MAX_BURST=1 releases after every beat.

Optional Feature:
MUXARB_FIXED_PRIO_EN: when defined, round robin is replaced by fixed priority 0>1>2. ptr is not implemented and the release path does not update it. When undefined, the round-robin behaviour above applies. All other behaviour is identical.

Test Plan:
- Reset then e_req=001, data 4'hA, e_last=1, e_ready=1: s_muxsel=00 at n+1, s_ack=001 at n+1, s_valid=1 with s_data=A and s_src=00 at n+2, s_muxsel=11 at n+2.
- e_req=111 held, every beat last: grant order 0,1,2,0,1,2; s_src matches; 1 idle cycle between grants. With MUXARB_FIXED_PRIO_EN: always 0.
- Requester 1 bursts 12 beats, no last, MAX_BURST=8, e_req=010 only: forced release after beat 8; regrant to 1 after the idle cycle; remaining 4 beats follow.
- e_ready=0 for 3 cycles mid-burst: s_data stable, s_ack=000 while s_valid=1, no beat lost or duplicated. Resume: sequence continues in order.
- rst asserted during BUSY beat 3: next cycle s_valid=0, s_muxsel=11, ptr=2. After release of rst with e_req=110: requester 1 granted.
- Granted requester deasserts e_req for 2 cycles: s_muxsel unchanged, no accepts. On reassert, beats resume and release occurs on last.
